// File: rtl/myprotocol_wavegen_pkg.sv
// Shared types and helpers for the multi-channel protocol waveform generator.
// Position fields are FRAME_W+1 bits wide so they can address every half-cycle of a frame.
package myprotocol_wavegen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mpw_state_e;

    function automatic int pos_w(input int frame_w);
        return frame_w + 1;
    endfunction

    // LSB of channel ch's rise/fall field inside the packed position buses
    function automatic int pos_lsb(input int ch, input int frame_w);
        return ch * pos_w(frame_w);
    endfunction

endpackage

// File: rtl/mpw_channel.sv
// One waveform channel: posedge bank (and, with MYPROTOCOL_NEGEDGE_EN, a negedge bank)
// whose XOR forms the channel output; each bank toggles only when its own edge changes the level.
module mpw_channel
    import myprotocol_wavegen_pkg::*;
#(
    parameter int PW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_act,
    input  logic [PW-1:0] h_pos,
`ifdef MYPROTOCOL_NEGEDGE_EN
    input  logic          n_act,
    input  logic [PW-1:0] h_neg,
`endif
    input  logic [PW-1:0] rise,
    input  logic [PW-1:0] fall,
    input  logic          clr,
    output logic          sig
);

    logic same;
    logic p_set;
    logic p_clr;
    logic sig_p;

    // rise==fall must never set, so clear alone decides and the channel stays low
    assign same  = (rise == fall);
    assign p_set = p_act && (h_pos == rise) && !same;
    assign p_clr = p_act && (h_pos == fall);

`ifdef MYPROTOCOL_NEGEDGE_EN
    logic n_set;
    logic n_clr;
    logic sig_n;

    assign n_set = n_act && (h_neg == rise) && !same;
    assign n_clr = n_act && (h_neg == fall);
    assign sig   = sig_p ^ sig_n;

    // Clearing from the posedge side copies the negedge bank, so the XOR drops to 0 at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_p <= 1'b0;
        end else if (clr) begin
            sig_p <= sig_n;
        end else if ((p_set && !sig) || (p_clr && sig)) begin
            sig_p <= ~sig_p;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            sig_n <= 1'b0;
        end else if ((n_set && !sig) || (n_clr && sig)) begin
            sig_n <= ~sig_n;
        end
    end
`else
    assign sig = sig_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_p <= 1'b0;
        end else if (clr) begin
            sig_p <= 1'b0;
        end else if ((p_set && !sig) || (p_clr && sig)) begin
            sig_p <= ~sig_p;
        end
    end
`endif

endmodule

// File: rtl/myprotocol_wavegen.sv
// Multi-channel framed pulse generator with half-cycle resolution.
// Build option MYPROTOCOL_NEGEDGE_EN enables the negedge bank; without it all edges are posedge.
//
// state | meaning
// IDLE  | waiting for start with a non-zero frame length
// RUN   | emitting frames; ends after num_frames frames or on stop
module myprotocol_wavegen
    import myprotocol_wavegen_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int FRAME_W = 8,
    parameter int NFRM_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic [FRAME_W-1:0]           frame_len,
    input  logic [NFRM_W-1:0]            num_frames,
    input  logic [NCH*(FRAME_W+1)-1:0]   rise_pos,
    input  logic [NCH*(FRAME_W+1)-1:0]   fall_pos,
    output logic [NCH-1:0]               sig,
    output logic                         busy,
    output logic                         done,
    output logic [NFRM_W-1:0]            frame_cnt
);

    localparam int PW = pos_w(FRAME_W);
    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_RUN  = 1'(RUN);

`ifdef MYPROTOCOL_NEGEDGE_EN
    localparam logic [NCH*PW-1:0] POS_MASK = '1;
`else
    function automatic logic [NCH*PW-1:0] lsb_mask();
        logic [NCH*PW-1:0] m;
        m = '1;
        for (int c = 0; c < NCH; c++) m[c*PW] = 1'b0;
        return m;
    endfunction
    // Without the negedge bank only even half-cycles exist, so odd positions round down
    localparam logic [NCH*PW-1:0] POS_MASK = lsb_mask();
`endif

    logic [0:0]         state;
    logic [FRAME_W-1:0] len_q;
    logic [NFRM_W-1:0]  nfrm_q;
    logic [NCH*PW-1:0]  rise_q;
    logic [NCH*PW-1:0]  fall_q;
    logic [FRAME_W-1:0] pos_c;
    logic               ph_act;

    logic               go;
    logic               in_run;
    logic               frame_end;
    logic               last_frame;
    logic               end_run;
    logic               run_edge;
    logic [FRAME_W-1:0] k_prev;
    logic [FRAME_W-1:0] k_cur;
    logic [PW-1:0]      h_pos;
    logic [NFRM_W-1:0]  frame_cnt_inc;

    assign in_run        = (state == S_RUN);
    assign busy          = in_run;
    assign go            = !in_run && start && (frame_len != '0);
    assign frame_cnt_inc = frame_cnt + 1'b1;

    // pos_c is the cycle index of the latest posedge; ph_act marks that one has happened this run
    assign frame_end  = in_run && ph_act && (k_prev == len_q - 1'b1);
    assign last_frame = frame_end && (nfrm_q != '0) && (frame_cnt_inc == nfrm_q);
    assign end_run    = in_run && (stop || last_frame);
    assign run_edge   = in_run && !end_run;
    assign k_cur      = (!ph_act || frame_end) ? '0 : pos_c + 1'b1;
    assign h_pos      = {k_cur, 1'b0};

`ifdef MYPROTOCOL_NEGEDGE_EN
    logic [FRAME_W-1:0] neg_c;
    logic [PW-1:0]      h_neg;
    logic               n_act;

    // The frame closes once the negedge of cycle L-1 has been seen
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            neg_c <= '0;
        end else begin
            neg_c <= pos_c;
        end
    end

    assign k_prev = neg_c;
    assign h_neg  = {pos_c, 1'b1};
    assign n_act  = in_run && ph_act;
`else
    assign k_prev = pos_c;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            nfrm_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pos_c     <= '0;
            ph_act    <= 1'b0;
            frame_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= end_run;
            if (go) begin
                state     <= S_RUN;
                len_q     <= frame_len;
                nfrm_q    <= num_frames;
                rise_q    <= rise_pos & POS_MASK;
                fall_q    <= fall_pos & POS_MASK;
                pos_c     <= '0;
                ph_act    <= 1'b0;
                frame_cnt <= '0;
            end else if (in_run) begin
                if (frame_end) begin
                    frame_cnt <= frame_cnt_inc;
                end
                if (end_run) begin
                    state  <= S_IDLE;
                    ph_act <= 1'b0;
                end else begin
                    pos_c  <= k_cur;
                    ph_act <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mpw_channel #(.PW(PW)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .p_act (run_edge),
            .h_pos (h_pos),
`ifdef MYPROTOCOL_NEGEDGE_EN
            .n_act (n_act),
            .h_neg (h_neg),
`endif
            .rise  (rise_q[pos_lsb(i, FRAME_W) +: PW]),
            .fall  (fall_q[pos_lsb(i, FRAME_W) +: PW]),
            .clr   (end_run),
            .sig   (sig[i])
        );
    end

endmodule
